// File: rtl/timer_ctrl.sv
// timer_ctrl: register-mapped controller for the 8-bit up/down timer counter.
//
// Holds the timer configuration registers (TDR, TCR, TSR, TIER), issues a
// one-pclk load strobe to the counter, derives the count clock clk_int from a
// free-running prescaler, and flags overflow/underflow by watching cnt and
// last_cnt. irq is the registered OR of the enabled flags.
//
// Optional build macro: TIMER_CTRL_WAIT_EN -- every bus access takes one wait
// state (pready low in the first access-phase cycle). Undefined: zero-wait.
//
// Ports:
//   pclk, preset_n          clock, async active-low reset
//   psel/penable/pwrite     APB-style control
//   paddr[2:0], pwdata[7:0] address / write data
//   prdata[7:0]             read data (access phase only, else 0)
//   pready, pslverr         transfer complete / unmapped-address error
//   cnt, last_cnt           counter value now and one half-cycle earlier
//   tdr                     reload value to the counter
//   load                    one-pclk load strobe
//   en, updw                count enable, direction (1 = down)
//   clk_int                 count clock (counter counts on its rising edge)
//   irq                     level interrupt, active high
module timer_ctrl #(
  parameter int          DIV_W   = 4,
  parameter logic [7:0]  RST_TDR = 8'h00
) (
  input  logic       pclk,
  input  logic       preset_n,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  input  logic [2:0] paddr,
  input  logic [7:0] pwdata,
  output logic [7:0] prdata,
  output logic       pready,
  output logic       pslverr,
  input  logic [7:0] cnt,
  input  logic [7:0] last_cnt,
  output logic [7:0] tdr,
  output logic       load,
  output logic       en,
  output logic       updw,
  output logic       clk_int,
  output logic       irq
);

  localparam logic [2:0] A_TDR  = 3'd0;
  localparam logic [2:0] A_TCR  = 3'd1;
  localparam logic [2:0] A_TSR  = 3'd2;
  localparam logic [2:0] A_TIER = 3'd3;
  localparam logic [2:0] A_TCNT = 3'd4;

  typedef enum logic {IDLE, STROBE} state_e;

  logic [7:0]       tdr_q;
  logic             updw_q, en_q;
  logic [1:0]       cks_q;
  logic             ovf_q, udf_q, ovf_d, udf_d;
  logic             ovfie_q, udfie_q;
  logic [DIV_W-1:0] presc_q;
  state_e           state_q;
  logic             load_q, sup_q, irq_q;
  logic             acc, wr_en, ld_req, sup, ovf_hit, udf_hit;
  logic [1:0]       w1c;
  logic [7:0]       rdata;

  assign acc = psel & penable;

`ifdef TIMER_CTRL_WAIT_EN
  // High only in the second access-phase cycle: one wait state per access.
  logic wait_q;
  always_ff @(posedge pclk or negedge preset_n)
    if (!preset_n) wait_q <= 1'b0;
    else           wait_q <= acc & ~wait_q;
  assign pready = wait_q;
`else
  assign pready = 1'b1;
`endif

  assign wr_en   = acc & pwrite & pready;
  assign ld_req  = wr_en & (paddr == A_TCR) & pwdata[7];
  assign pslverr = acc & pready & (paddr > A_TCNT);

  always_comb begin
    rdata = 8'h00;
    case (paddr)
      A_TDR:  rdata = tdr_q;
      A_TCR:  rdata = {2'b00, updw_q, en_q, 2'b00, cks_q};
      A_TSR:  rdata = {6'b0, udf_q, ovf_q};
      A_TIER: rdata = {6'b0, udfie_q, ovfie_q};
      A_TCNT: rdata = cnt;
      default: rdata = 8'h00;
    endcase
  end
  assign prdata = (acc & ~pwrite & pready) ? rdata : 8'h00;

  // Reload makes cnt jump; ignore the strobe cycle and the one after it.
  assign sup     = load_q | sup_q;
  assign ovf_hit = en_q & ~updw_q & (last_cnt == 8'hFF) & (cnt == 8'h00) & ~sup;
  assign udf_hit = en_q &  updw_q & (last_cnt == 8'h00) & (cnt == 8'hFF) & ~sup;
  assign w1c     = (wr_en && paddr == A_TSR) ? pwdata[1:0] : 2'b00;
  // Hardware set wins over a same-edge software clear.
  assign ovf_d   = ovf_hit | (ovf_q & ~w1c[0]);
  assign udf_d   = udf_hit | (udf_q & ~w1c[1]);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      tdr_q   <= RST_TDR;
      updw_q  <= 1'b0;
      en_q    <= 1'b0;
      cks_q   <= 2'b00;
      ovfie_q <= 1'b0;
      udfie_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      presc_q <= '0;
      sup_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_en && paddr == A_TDR) tdr_q <= pwdata;
      if (wr_en && paddr == A_TCR) begin
        updw_q <= pwdata[5];
        en_q   <= pwdata[4];
        cks_q  <= pwdata[1:0];
      end
      if (wr_en && paddr == A_TIER) begin
        ovfie_q <= pwdata[0];
        udfie_q <= pwdata[1];
      end
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      presc_q <= presc_q + 1'b1;
      sup_q   <= load_q;
      irq_q   <= (ovf_q & ovfie_q) | (udf_q & udfie_q);
    end
  end

  // Load strobe FSM; a LOAD write while strobing extends into a new strobe.
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (ld_req) begin
          state_q <= STROBE;
          load_q  <= 1'b1;
        end
        STROBE: begin
          state_q <= ld_req ? STROBE : IDLE;
          load_q  <= ld_req;
        end
        default: begin
          state_q <= IDLE;
          load_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tdr     = tdr_q;
  assign load    = load_q;
  assign en      = en_q;
  assign updw    = updw_q;
  assign clk_int = presc_q[cks_q];
  assign irq     = irq_q;

endmodule
